// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, redirect/stall control
// from later stages, and the instruction presented to decode.
interface fetch_stage_if;
  logic        stall_fetch;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] IF_instr_data;
  logic [31:0] IF_pc;
  logic [31:0] IF_pc_rdata;
  logic        fetch_busy;

  modport master (
    input  stall_fetch, mispredict, redirect_pc, imem_resp, imem_rdata,
    output imem_read, imem_address, IF_instr_data, IF_pc, IF_pc_rdata, fetch_busy
  );

  modport slave (
    output stall_fetch, mispredict, redirect_pc, imem_resp, imem_rdata,
    input  imem_read, imem_address, IF_instr_data, IF_pc, IF_pc_rdata, fetch_busy
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, a single-entry output
// buffer for decode, and redirect handling that discards stale responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_e;

  state_e      state_q, state_d;
  logic        active_q;
  logic [31:0] pc_q;
  logic [31:0] stale_q;
  logic [31:0] instr_q;
  logic [31:0] ipc_q;
  logic        resp;
  logic        capture;

  // No request is outstanding until the first edge after reset, so a response
  // seen before then is not ours.
  assign resp = bus.imem_resp & active_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REQ;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d           = state_q;
    capture           = 1'b0;
    bus.imem_read     = 1'b0;
    bus.imem_address  = 32'h0;
    bus.IF_instr_data = 32'h0;
    bus.IF_pc         = 32'h0;
    bus.IF_pc_rdata   = 32'h0;
    bus.fetch_busy    = 1'b1;

    unique case (state_q)
      REQ: begin
        bus.imem_read    = active_q;
        bus.imem_address = active_q ? pc_q : 32'h0;
        if (bus.mispredict) begin
          // A request still in flight must be drained before re-issuing.
          state_d = (resp || !active_q) ? REQ : DISCARD;
        end else if (resp) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        bus.IF_instr_data = instr_q;
        bus.IF_pc         = ipc_q;
        bus.IF_pc_rdata   = ipc_q + 32'd4;
        bus.fetch_busy    = 1'b0;
        if (bus.mispredict || !bus.stall_fetch) state_d = REQ;
      end
      DISCARD: begin
        bus.imem_read    = 1'b1;
        bus.imem_address = stale_q;
        if (resp) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stale_q <= 32'h0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
    end else begin
      if (state_q == REQ && state_d == DISCARD) stale_q <= pc_q;

      if (bus.mispredict) begin
        pc_q <= {bus.redirect_pc[31:2], 2'b00};
        if (state_q == HOLD) begin
          instr_q <= 32'h0;
          ipc_q   <= 32'h0;
        end
      end else if (capture) begin
        instr_q <= bus.imem_rdata;
        ipc_q   <= pc_q;
        pc_q    <= pc_q + 32'd4;
      end else if (state_q == HOLD && !bus.stall_fetch) begin
        instr_q <= 32'h0;
        ipc_q   <= 32'h0;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h4000_0000, PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall_fetch  input  1  downstream hold; decode not accepting a new instruction.
REQ-005 SHALL have port mispredict  input  1  redirect request, one-cycle pulse.
REQ-006 SHALL have port redirect_pc  input  32  target PC, valid while mispredict=1.
REQ-007 SHALL have port imem_resp  input  1  instruction memory response, one-cycle pulse.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid while imem_resp=1.
REQ-009 SHALL have port imem_read  output  1  memory read request, held until imem_resp.
REQ-010 SHALL have port imem_address  output  32  fetch address, word aligned, stable while imem_read=1.
REQ-011 SHALL have port IF_instr_data  output  32  fetched instruction; 32'h0 marks a bubble.
REQ-012 SHALL have port IF_pc  output  32  PC of IF_instr_data.
REQ-013 SHALL have port IF_pc_rdata  output  32  predicted next PC, IF_pc+4.
REQ-014 SHALL have port fetch_busy  output  1  no valid instruction presented this cycle.

Function
REQ-015 SHALL hold one request in flight at most, issued from fetch PC register pc_q.
REQ-016 SHALL implement states REQ, HOLD and DISCARD.
REQ-017 In REQ, SHALL drive imem_read=1 and imem_address=pc_q.
REQ-018 In REQ on imem_resp with no mispredict, SHALL capture imem_rdata and pc_q into an output buffer, set pc_q=pc_q+4 and go to HOLD.
REQ-019 In HOLD, SHALL present the buffer on IF_instr_data/IF_pc/IF_pc_rdata with fetch_busy=0 and imem_read=0.
REQ-020 In HOLD with stall_fetch=0, the buffer SHALL be consumed at that edge and the state SHALL go to REQ, with zero-bubble re-issue the same cycle permitted.
REQ-021 In HOLD with stall_fetch=1, SHALL keep buffer and state unchanged.
REQ-022 When not in HOLD, SHALL drive IF_instr_data=0, IF_pc=0, IF_pc_rdata=0 and fetch_busy=1.
REQ-023 On mispredict in HOLD or REQ without imem_resp, SHALL set pc_q=redirect_pc, invalidate the buffer and enter REQ or DISCARD respectively; mispredict SHALL take priority over stall_fetch.
REQ-024 On mispredict coinciding with imem_resp in REQ, SHALL drop the response, set pc_q=redirect_pc and stay in REQ.
REQ-025 In DISCARD, SHALL keep imem_read=1 at the stale address; on imem_resp it SHALL drop the data and go to REQ, issuing pc_q on the next cycle.
REQ-026 On mispredict in DISCARD, SHALL update pc_q=redirect_pc and remain in DISCARD.
REQ-027 SHALL compute PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 SHALL force redirect_pc[1:0] to 0 when loaded.
REQ-029 SHALL give a latency of one cycle from imem_resp to a valid IF_instr_data.

Reset
REQ-030 On rst=1, SHALL asynchronously set pc_q=RESET_PC, clear the buffer and enter REQ.
REQ-031 Within reset, SHALL drive imem_read=0, IF_* outputs=0 and fetch_busy=1.
REQ-032 SHALL ignore an imem_resp arriving while rst=1.
REQ-033 SHALL raise imem_read=1 at RESET_PC on the first edge after rst deasserts.

Verification
REQ-034 Reset release, memory returning 32'h00000013 after 2 cycles -> imem_address=32'h4000_0000, next cycle IF_instr_data=32'h13, IF_pc=32'h4000_0000, IF_pc_rdata=32'h4000_0004.
REQ-035 stall_fetch=1 for 3 cycles while in HOLD -> outputs constant, imem_read=0; release -> next request at 32'h4000_0004.
REQ-036 mispredict, redirect_pc=32'h4000_0100 while the request is pending -> stale response dropped (IF_instr_data stays 0), next request address 32'h4000_0100.
REQ-037 mispredict coincident with imem_resp -> no instruction presented, next request at redirect_pc.
REQ-038 pc_q=32'hFFFF_FFFC, response received -> next address 32'h0000_0000.
REQ-039 rst asserted mid-request -> outputs cleared immediately, no clock required; after release, fetch resumes at RESET_PC.
